// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operation encoding,
// sequencer states and the default operand width.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: a shift-add multiply step or a
// restoring shift-subtract divide step on a 2*WIDTH accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: upper half gains the multiplicand when the multiplier LSB is set.
        sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
        // Divide: remainder shifted left with the next dividend bit pulled in.
        rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
        fits   = rem_sh >= {1'b0, operand};
        diff   = rem_sh[WIDTH-1:0] - operand;

        if (is_div) begin
            if (fits) begin
                acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with a start/busy/done
// handshake for pipeline stalls, flush abort and MTHI/MTLO writes.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned     CW   = $clog2(ITER);
    localparam logic [CW-1:0]   LAST = CW'(ITER - 1);

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic                 is_div, is_signed;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   step_out, prod;
    logic [WIDTH-1:0]     quo, rem, res_hi, res_lo;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    assign busy = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (is_div),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (step_out)
    );

    // Sign fix-up; divide by zero bypasses it and reports the raw dividend.
    always_comb begin
        prod = neg_quo_q ? -acc_q : acc_q;
        quo  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && !flush) begin
                    state_d = PREP;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                end
            end
            PREP: begin
                opnd_d    = is_div ? abs_b : abs_a;
                acc_d     = {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                cnt_d     = '0;
                neg_quo_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = is_signed & a_q[WIDTH-1];
                state_d   = RUN;
            end
            RUN: begin
                acc_d = step_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (busy && flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        if (!busy) begin
            if (wr_hi) hi_d = wdata;
            if (wr_lo) lo_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a driver queues expected HI/LO and done cycle,
// a monitor pops and compares whenever done is presented.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush, wr_hi, wr_lo;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0, pend_hi = 0, pend_lo = 0;
    int          nb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference: plain signed/unsigned arithmetic, SV division truncates toward zero.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sx = $signed(x);
        longint      sy = $signed(y);
        longint      p;
        logic [63:0] u;
        case (o)
            2'b00: begin p = sx * sy; {h, l} = p; end
            2'b01: begin u = 64'(x) * 64'(y); {h, l} = u; end
            2'b10: begin
                if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
                else begin l = 32'(sx / sy); h = 32'(sx % sy); end
            end
            default: begin
                if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
                else begin l = x / y; h = x % y; end
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            check("busy_with_done", 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic kick(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit hold);
        op = o; a = x; b = y; start = 1'b1;
        step();
        if (!hold) begin
            start = 1'b0;
            op = 2'($urandom); a = $urandom; b = $urandom;
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit hold);
        logic [31:0] eh, el;
        model(o, x, y, eh, el);
        sb.push_back('{eh, el, cyc + 35});
        pend_hi = eh; pend_lo = el;
        kick(o, x, y, hold);
    endtask

    task automatic wait_done(output int nbusy);
        nbusy = 0;
        for (int n = 0; n < 100; n++) begin
            if (done) break;
            if (busy) nbusy++;
            step();
        end
        check("done_seen", 64'(done), 64'd1);
        exp_hi = pend_hi; exp_lo = pend_lo;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 0; b = 0;
        flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = 0;
        repeat (3) step();
        rst_n = 1'b1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        step();

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(nb);
        check("busy_cycles", 64'(nb), 64'd34);
        step();

        launch(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_done(nb);
        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(nb);
        launch(2'b11, 32'd7, 32'd0, 1'b0);
        wait_done(nb);
        launch(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0);
        wait_done(nb);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(nb);
        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done(nb);
        step();

        // Back-to-back issue with start held through DONE.
        launch(2'b11, 32'd100, 32'd7, 1'b1);
        wait_done(nb);
        launch(2'b01, 32'd3, 32'd5, 1'b0);
        wait_done(nb);

        // Write strobe in DONE overrides the fresh result.
        wr_hi = 1'b1; wdata = 32'hCAFE_F00D;
        step();
        wr_hi = 1'b0;
        exp_hi = 32'hCAFE_F00D;
        check("done_write_hi", 64'(hi), 64'(exp_hi));
        check("done_write_lo", 64'(lo), 64'(exp_lo));

        // Flush in RUN, with an ignored start pulse while busy.
        wr_hi = 1'b1; wdata = 32'hAAAA_0000;
        step();
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h0000_5555;
        step();
        wr_lo = 1'b0;
        check("mthi", 64'(hi), 64'h0000_0000_AAAA_0000);
        check("mtlo", 64'(lo), 64'h0000_0000_0000_5555);
        kick(2'b01, $urandom, $urandom, 1'b0);
        repeat (4) step();
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
        step();
        start = 1'b0;
        repeat (6) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(hi), 64'h0000_0000_AAAA_0000);
        check("flush_lo", 64'(lo), 64'h0000_0000_0000_5555);
        repeat (3) step();
        check("flush_stays_idle", 64'(busy), 64'd0);
        exp_hi = 32'hAAAA_0000; exp_lo = 32'h0000_5555;

        // Start while busy must not disturb the running operation.
        launch(2'b10, 32'hFFFF_FF00, 32'd13, 1'b0);
        repeat (5) step();
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
        step();
        start = 1'b0;
        wait_done(nb);

        // Flush together with start in DONE: start not accepted.
        flush = 1'b1; start = 1'b1; op = 2'b01; a = 32'd4; b = 32'd4;
        step();
        flush = 1'b0; start = 1'b0;
        check("done_flush_busy", 64'(busy), 64'd0);
        check("done_flush_hi", 64'(hi), 64'(exp_hi));

        // Flush with start in IDLE: flush wins.
        flush = 1'b1; start = 1'b1;
        step();
        flush = 1'b0; start = 1'b0;
        check("idle_flush_busy", 64'(busy), 64'd0);

        // Reset in the middle of RUN.
        kick(2'b00, $urandom, $urandom, 1'b0);
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrun_rst_hi", 64'(hi), 64'd0);
        check("midrun_rst_lo", 64'(lo), 64'd0);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_done", 64'(done), 64'd0);

        wr_hi = 1'b1; wdata = 32'h1234_5678;
        step();
        wr_hi = 1'b0;
        check("idle_wr_hi", 64'(hi), 64'h0000_0000_1234_5678);
        check("idle_wr_hi_lo", 64'(lo), 64'd0);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0BAD_BEEF;
        step();
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("both_wr_hi", 64'(hi), 64'h0000_0000_0BAD_BEEF);
        check("both_wr_lo", 64'(lo), 64'h0000_0000_0BAD_BEEF);
        exp_hi = 32'h0BAD_BEEF; exp_lo = 32'h0BAD_BEEF;

        // MTLO while busy is ignored.
        launch(2'b01, 32'd123, 32'd456, 1'b0);
        repeat (3) step();
        wr_lo = 1'b1; wdata = 32'h1111_1111;
        step();
        wr_lo = 1'b0;
        check("busy_wr_lo", 64'(lo), 64'(exp_lo));
        wait_done(nb);

        // Write together with an accepted start: applies now, result overwrites later.
        step();
        wr_lo = 1'b1; wdata = 32'h0000_DEAD;
        launch(2'b11, 32'd1000, 32'd33, 1'b0);
        wr_lo = 1'b0;
        check("start_wr_lo", 64'(lo), 64'h0000_0000_0000_DEAD);
        wait_done(nb);

        for (int i = 0; i < 40; i++) begin
            launch(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
            wait_done(nb);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
